// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the pipelined core: streams program and data images into the
// core's memories, runs the core for a fixed cycle count, then streams a data window out.
module cpu_run_ctrl #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [9:0]       imem_words,
  input  logic [10:0]      dmem_words,
  input  logic [10:0]      dump_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [31:0]      m_data,
  input  logic             m_ready,
  output logic             cpu_enable,
  output logic [31:0]      imem_addr,
  output logic             imem_wen,
  output logic [31:0]      imem_wdata,
  output logic [31:0]      dmem_addr,
  output logic             dmem_wen,
  output logic             dmem_ren,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] RD_LAT_V = LAT_W'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, RD_ISSUE, RD_WAIT, RD_OUT, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        imem_words_q, imem_words_d;
  logic [10:0]       dmem_words_q, dmem_words_d;
  logic [10:0]       dump_words_q, dump_words_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic [10:0]       idx_q, idx_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       m_data_q, m_data_d;

  logic              beat_i;
  logic              beat_d;
  logic [31:0]       idx_addr;

  // First phase with a non-zero count that still lies ahead of 'cur'; IDLE means "from the top".
  function automatic state_e phase_after(input state_e cur, input logic [9:0] iw,
                                         input logic [10:0] dw, input logic [CNT_W-1:0] rc,
                                         input logic [10:0] dpw);
    state_e nxt;
    nxt = DONE;
    if (dpw != '0) nxt = RD_ISSUE;
    if (rc != '0 && (cur == IDLE || cur == LOAD_I || cur == LOAD_D)) nxt = RUN;
    if (dw != '0 && (cur == IDLE || cur == LOAD_I)) nxt = LOAD_D;
    if (iw != '0 && cur == IDLE) nxt = LOAD_I;
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      imem_words_q <= '0;
      dmem_words_q <= '0;
      dump_words_q <= '0;
      run_cycles_q <= '0;
      idx_q        <= '0;
      run_cnt_q    <= '0;
      lat_q        <= '0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      imem_words_q <= imem_words_d;
      dmem_words_q <= dmem_words_d;
      dump_words_q <= dump_words_d;
      run_cycles_q <= run_cycles_d;
      idx_q        <= idx_d;
      run_cnt_q    <= run_cnt_d;
      lat_q        <= lat_d;
      m_data_q     <= m_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    imem_words_d = imem_words_q;
    dmem_words_d = dmem_words_q;
    dump_words_d = dump_words_q;
    run_cycles_d = run_cycles_q;
    idx_d        = idx_q;
    run_cnt_d    = run_cnt_q;
    lat_d        = lat_q;
    m_data_d     = m_data_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          imem_words_d = imem_words;
          dmem_words_d = dmem_words;
          dump_words_d = dump_words;
          run_cycles_d = run_cycles;
          idx_d        = '0;
          run_cnt_d    = '0;
          lat_d        = '0;
          state_d      = phase_after(IDLE, imem_words, dmem_words, run_cycles, dump_words);
        end
      end
      LOAD_I: begin
        if (s_valid) begin
          if (idx_q == 11'(imem_words_q) - 11'd1) begin
            idx_d   = '0;
            state_d = phase_after(LOAD_I, imem_words_q, dmem_words_q, run_cycles_q, dump_words_q);
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end
      LOAD_D: begin
        if (s_valid) begin
          if (idx_q == dmem_words_q - 11'd1) begin
            idx_d   = '0;
            state_d = phase_after(LOAD_D, imem_words_q, dmem_words_q, run_cycles_q, dump_words_q);
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end
      RUN: begin
        if (run_cnt_q == run_cycles_q - CNT_W'(1)) begin
          idx_d   = '0;
          state_d = phase_after(RUN, imem_words_q, dmem_words_q, run_cycles_q, dump_words_q);
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end
      RD_ISSUE: begin
        lat_d   = LAT_W'(1);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // lat_q counts cycles since the issue cycle; the read data is valid once it hits RD_LAT
        if (lat_q == RD_LAT_V) begin
          m_data_d = dmem_rdata;
          state_d  = RD_OUT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RD_OUT: begin
        if (m_ready) begin
          if (idx_q == dump_words_q - 11'd1) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 11'd1;
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_i     = (state_q == LOAD_I) && s_valid;
    beat_d     = (state_q == LOAD_D) && s_valid;
    idx_addr   = 32'(idx_q) * 32'(ADDR_STEP);

    s_ready    = (state_q == LOAD_I) || (state_q == LOAD_D);
    imem_wen   = beat_i;
    imem_addr  = beat_i ? idx_addr : 32'h0;
    imem_wdata = beat_i ? s_data : 32'h0;
    dmem_wen   = beat_d;
    dmem_ren   = (state_q == RD_ISSUE);
    dmem_addr  = (beat_d || state_q == RD_ISSUE || state_q == RD_WAIT) ? idx_addr : 32'h0;
    dmem_wdata = beat_d ? s_data : 32'h0;
    cpu_enable = (state_q == RUN);
    m_valid    = (state_q == RD_OUT);
    m_data     = (state_q == RD_OUT) ? m_data_q : 32'h0;
    busy       = (state_q != IDLE) && (state_q != DONE);
    done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: cycle vector tables for the full run and backpressure,
// hand sequences for reset, zero counts, start-while-busy and a second instance with RD_LAT=2.
module tb_cpu_run_ctrl;

  typedef struct packed {
    logic        s_ready;
    logic        imem_wen;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_wen;
    logic        dmem_ren;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        cpu_enable;
    logic        m_valid;
    logic [31:0] m_data;
    logic        busy;
    logic        done;
  } outs_t;

  typedef struct {
    logic        start;
    logic        s_valid;
    logic [31:0] s_data;
    logic        m_ready;
    outs_t       exp;
  } vec_t;

  logic        clk, arst_n, start, start2;
  logic [9:0]  imem_words;
  logic [10:0] dmem_words, dump_words;
  logic [31:0] run_cycles;
  logic        s_valid, m_ready;
  logic [31:0] s_data;

  logic        s_ready, m_valid, cpu_enable, imem_wen, dmem_wen, dmem_ren, busy, done;
  logic [31:0] m_data, imem_addr, imem_wdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        s_ready2, m_valid2, cpu_enable2, imem_wen2, dmem_wen2, dmem_ren2, busy2, done2;
  logic [31:0] m_data2, imem_addr2, imem_wdata2, dmem_addr2, dmem_wdata2, dmem_rdata2;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  cpu_run_ctrl #(.ADDR_STEP(4), .RD_LAT(1), .CNT_W(32)) u_dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words), .dump_words(dump_words),
    .run_cycles(run_cycles), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .cpu_enable(cpu_enable),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .busy(busy), .done(done)
  );

  cpu_run_ctrl #(.ADDR_STEP(4), .RD_LAT(2), .CNT_W(32)) u_dut2 (
    .clk(clk), .arst_n(arst_n), .start(start2),
    .imem_words(imem_words), .dmem_words(dmem_words), .dump_words(dump_words),
    .run_cycles(run_cycles), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2),
    .m_valid(m_valid2), .m_data(m_data2), .m_ready(m_ready), .cpu_enable(cpu_enable2),
    .imem_addr(imem_addr2), .imem_wen(imem_wen2), .imem_wdata(imem_wdata2),
    .dmem_addr(dmem_addr2), .dmem_wen(dmem_wen2), .dmem_ren(dmem_ren2),
    .dmem_wdata(dmem_wdata2), .dmem_rdata(dmem_rdata2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data-memory models: one-cycle and two-cycle read latency after the ren cycle.
  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];
  logic [31:0] p1 = 32'h0, p2a = 32'h0, p2b = 32'h0;
  always @(posedge clk) begin
    if (dmem_wen) mem1[dmem_addr[5:2]] <= dmem_wdata;
    if (dmem_ren) p1 <= mem1[dmem_addr[5:2]];
    if (dmem_wen2) mem2[dmem_addr2[5:2]] <= dmem_wdata2;
    if (dmem_ren2) p2a <= mem2[dmem_addr2[5:2]];
    p2b <= p2a;
  end
  assign dmem_rdata  = p1;
  assign dmem_rdata2 = p2b;

  always @(negedge clk) begin
    #3;
    if (int'(imem_wen) + int'(dmem_wen) + int'(cpu_enable) > 1) viol++;
    if (int'(imem_wen2) + int'(dmem_wen2) + int'(cpu_enable2) > 1) viol++;
  end

  function automatic outs_t mko(logic sr, logic iw, logic [31:0] ia, logic [31:0] iwd,
                                logic dw, logic dr, logic [31:0] da, logic [31:0] dwd,
                                logic en, logic mv, logic [31:0] md, logic bsy, logic dn);
    outs_t o;
    o = '{sr, iw, ia, iwd, dw, dr, da, dwd, en, mv, md, bsy, dn};
    return o;
  endfunction

  function automatic vec_t mkv(logic st, logic sv, logic [31:0] sd, logic mr, outs_t e);
    vec_t v;
    v.start = st; v.s_valid = sv; v.s_data = sd; v.m_ready = mr; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Drive one cycle of inputs right after the falling edge, compare before the rising edge.
  task automatic apply(input vec_t v, input string name);
    outs_t act;
    start = v.start; s_valid = v.s_valid; s_data = v.s_data; m_ready = v.m_ready;
    #2;
    act = '{s_ready, imem_wen, imem_wen ? imem_addr : 32'h0, imem_wen ? imem_wdata : 32'h0,
            dmem_wen, dmem_ren, dmem_addr, dmem_wen ? dmem_wdata : 32'h0,
            cpu_enable, m_valid, m_valid ? m_data : 32'h0, busy, done};
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, v.exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] A0 = 32'h00000013, A1 = 32'h00100093, A2 = 32'h00208113;
  localparam logic [31:0] D0 = 32'h0BADF00D, D1 = 32'hDEADBEEF;
  localparam logic [31:0] B0 = 32'h1111AAAA, B1 = 32'h2222BBBB;
  localparam logic [31:0] C0 = 32'h3333CCCC, C1 = 32'h4444DDDD;

  vec_t full_tbl [18];
  vec_t bp_tbl [19];
  outs_t z, o_busy, o_done, o_run;

  initial begin
    int en_cnt, act_cnt, nb;
    logic fin;
    logic [31:0] beat [2];
    int when [2];

    z      = '0;
    o_busy = mko(0,0,0,0, 0,0,0,0, 0,0,0, 1,0);
    o_done = mko(0,0,0,0, 0,0,0,0, 0,0,0, 0,1);
    o_run  = mko(0,0,0,0, 0,0,0,0, 1,0,0, 1,0);

    full_tbl[0]  = mkv(1,1,A0,1, o_done);
    full_tbl[1]  = mkv(0,1,A0,1, mko(1,1,32'h0,A0, 0,0,0,0, 0,0,0, 1,0));
    full_tbl[2]  = mkv(0,1,A1,1, mko(1,1,32'h4,A1, 0,0,0,0, 0,0,0, 1,0));
    full_tbl[3]  = mkv(0,1,A2,1, mko(1,1,32'h8,A2, 0,0,0,0, 0,0,0, 1,0));
    full_tbl[4]  = mkv(0,1,D0,1, mko(1,0,0,0, 1,0,32'h0,D0, 0,0,0, 1,0));
    full_tbl[5]  = mkv(0,1,D1,1, mko(1,0,0,0, 1,0,32'h4,D1, 0,0,0, 1,0));
    for (int i = 6; i <= 10; i++) full_tbl[i] = mkv(0,1,32'h0,1, o_run);
    full_tbl[11] = mkv(0,1,0,1, mko(0,0,0,0, 0,1,32'h0,0, 0,0,0, 1,0));
    full_tbl[12] = mkv(0,1,0,1, mko(0,0,0,0, 0,0,32'h0,0, 0,0,0, 1,0));
    full_tbl[13] = mkv(0,1,0,1, mko(0,0,0,0, 0,0,0,0, 0,1,D0, 1,0));
    full_tbl[14] = mkv(0,1,0,1, mko(0,0,0,0, 0,1,32'h4,0, 0,0,0, 1,0));
    full_tbl[15] = mkv(0,1,0,1, mko(0,0,0,0, 0,0,32'h4,0, 0,0,0, 1,0));
    full_tbl[16] = mkv(0,1,0,1, mko(0,0,0,0, 0,0,0,0, 0,1,D1, 1,0));
    full_tbl[17] = mkv(0,1,0,1, o_done);

    bp_tbl[0]  = mkv(1,0,0,0, o_done);
    bp_tbl[1]  = mkv(0,1,B0,0, mko(1,1,32'h0,B0, 0,0,0,0, 0,0,0, 1,0));
    bp_tbl[2]  = mkv(0,0,0,0, mko(1,0,0,0, 0,0,0,0, 0,0,0, 1,0));
    bp_tbl[3]  = mkv(0,1,B1,0, mko(1,1,32'h4,B1, 0,0,0,0, 0,0,0, 1,0));
    bp_tbl[4]  = mkv(0,0,0,0, mko(1,0,0,0, 0,0,0,0, 0,0,0, 1,0));
    bp_tbl[5]  = mkv(0,1,C0,0, mko(1,0,0,0, 1,0,32'h0,C0, 0,0,0, 1,0));
    bp_tbl[6]  = mkv(0,0,0,0, mko(1,0,0,0, 0,0,0,0, 0,0,0, 1,0));
    bp_tbl[7]  = mkv(0,1,C1,0, mko(1,0,0,0, 1,0,32'h4,C1, 0,0,0, 1,0));
    bp_tbl[8]  = mkv(0,0,0,0, mko(0,0,0,0, 0,1,32'h0,0, 0,0,0, 1,0));
    bp_tbl[9]  = mkv(0,0,0,0, mko(0,0,0,0, 0,0,32'h0,0, 0,0,0, 1,0));
    for (int i = 10; i <= 13; i++) bp_tbl[i] = mkv(0,0,0,0, mko(0,0,0,0, 0,0,0,0, 0,1,C0, 1,0));
    bp_tbl[14] = mkv(0,0,0,1, mko(0,0,0,0, 0,0,0,0, 0,1,C0, 1,0));
    bp_tbl[15] = mkv(0,0,0,1, mko(0,0,0,0, 0,1,32'h4,0, 0,0,0, 1,0));
    bp_tbl[16] = mkv(0,0,0,1, mko(0,0,0,0, 0,0,32'h4,0, 0,0,0, 1,0));
    bp_tbl[17] = mkv(0,0,0,1, mko(0,0,0,0, 0,0,0,0, 0,1,C1, 1,0));
    bp_tbl[18] = mkv(0,0,0,1, o_done);

    arst_n = 1'b0; start = 0; start2 = 0; s_valid = 0; s_data = 0; m_ready = 0;
    imem_words = 0; dmem_words = 0; dump_words = 0; run_cycles = 0;
    repeat (2) @(negedge clk);
    apply(mkv(0,1,32'h5,1, z), "reset_state");
    arst_n = 1'b1;
    apply(mkv(0,1,32'h5,1, z), "idle_after_reset");

    // All-zero counts: IDLE straight to DONE with no memory or enable activity.
    apply(mkv(1,1,32'h5,1, z), "zero_start");
    apply(mkv(0,1,32'h5,1, o_done), "zero_done");
    apply(mkv(0,1,32'h5,1, o_done), "zero_done_held");

    imem_words = 3; dmem_words = 2; run_cycles = 5; dump_words = 2;
    for (int i = 0; i < 18; i++) apply(full_tbl[i], $sformatf("full[%0d]", i));

    imem_words = 2; dmem_words = 2; run_cycles = 0; dump_words = 2;
    for (int i = 0; i < 19; i++) apply(bp_tbl[i], $sformatf("bp[%0d]", i));

    // Reset in the middle of an instruction load, then reload from address 0.
    imem_words = 4; dmem_words = 0; run_cycles = 0; dump_words = 0;
    apply(mkv(1,1,32'hE0,1, o_done), "rst_start");
    apply(mkv(0,1,32'hE0,1, mko(1,1,32'h0,32'hE0, 0,0,0,0, 0,0,0, 1,0)), "rst_beat0");
    apply(mkv(0,1,32'hE1,1, mko(1,1,32'h4,32'hE1, 0,0,0,0, 0,0,0, 1,0)), "rst_beat1");
    arst_n = 1'b0;
    apply(mkv(0,1,32'hE2,1, z), "rst_async_outputs");
    arst_n = 1'b1;
    apply(mkv(0,1,32'hE2,1, z), "rst_idle");
    imem_words = 1;
    apply(mkv(1,1,32'hE9,1, z), "rst_restart");
    apply(mkv(0,1,32'hE9,1, mko(1,1,32'h0,32'hE9, 0,0,0,0, 0,0,0, 1,0)), "rst_reload_addr0");
    apply(mkv(0,0,32'h0,1, o_done), "rst_reload_done");

    // Start pulse during RUN must be ignored and the latched counts kept.
    imem_words = 0; dmem_words = 0; run_cycles = 10; dump_words = 0; s_valid = 0;
    start = 1;
    @(negedge clk);
    en_cnt = 0; act_cnt = 0; fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      if (i == 3) begin
        start = 1; run_cycles = 3; imem_words = 1;
      end else begin
        start = 0;
      end
      #2;
      if (cpu_enable) en_cnt++;
      if (imem_wen || dmem_wen || dmem_ren) act_cnt++;
      if (done) fin = 1;
      @(negedge clk);
    end
    start = 0;
    chk("busy_start_done_reached", 32'(fin), 32'd1);
    chk("busy_start_enable_cycles", 32'(en_cnt), 32'd10);
    chk("busy_start_mem_activity", 32'(act_cnt), 32'd0);

    // Second instance with RD_LAT=2: load two data words, dump them back.
    imem_words = 0; dmem_words = 2; run_cycles = 0; dump_words = 2; m_ready = 1;
    start2 = 1; s_valid = 1; s_data = 32'h11111111;
    @(negedge clk);
    start2 = 0;
    @(negedge clk);
    s_data = D1;
    @(negedge clk);
    s_valid = 0;
    nb = 0; fin = 0; beat[0] = 0; beat[1] = 0; when[0] = 0; when[1] = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      #2;
      if (m_valid2 && m_ready) begin
        if (nb < 2) begin
          beat[nb] = m_data2;
          when[nb] = i;
        end
        nb++;
      end
      if (done2) fin = 1;
      @(negedge clk);
    end
    chk("lat2_done_reached", 32'(fin), 32'd1);
    chk("lat2_beat_count", 32'(nb), 32'd2);
    chk("lat2_beat0", beat[0], 32'h11111111);
    chk("lat2_beat1", beat[1], D1);
    chk("lat2_beat_spacing", 32'(when[1] - when[0]), 32'd4);

    chk("no_wen_enable_overlap", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Sequencer wrapped around the pipelined CPU core. It owns the core's external instruction-memory and data-memory ports and its enable input.
- After a start pulse it streams a program image into instruction memory and an initial image into data memory. It then runs the core for a programmed cycle count and streams a data-memory window back out.
- It is the single owner of the core's enable and external memory ports during operation.

Parameters:
- ADDR_STEP, 4, byte-address increment per 32-bit word on both memories.
- RD_LAT, 1, data-memory external read latency in cycles (ren_ext to rdata_ext valid).
- CNT_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  core clock.
- arst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse; honoured only in IDLE or DONE.
- imem_words  in  10  number of words to load into instruction memory; sampled at start.
- dmem_words  in  11  number of words to load into data memory; sampled at start.
- dump_words  in  11  number of data-memory words to read back; sampled at start.
- run_cycles  in  CNT_W  number of cycles to hold cpu_enable high; sampled at start.
- s_valid  in  1  load-stream word valid.
- s_data  in  32  load-stream word.
- s_ready  out  1  load-stream ready.
- m_valid  out  1  dump-stream word valid.
- m_data  out  32  dump-stream word.
- m_ready  in  1  dump-stream ready.
- cpu_enable  out  1  drives the core's enable input.
- imem_addr  out  32  core addr_ext.
- imem_wen  out  1  core wen_ext.
- imem_wdata  out  32  core wdata_ext.
- dmem_addr  out  32  core addr_ext_2.
- dmem_wen  out  1  core wen_ext_2.
- dmem_ren  out  1  core ren_ext_2.
- dmem_wdata  out  32  core wdata_ext_2.
- dmem_rdata  in  32  core rdata_ext_2.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Asynchronous reset mid-operation returns to IDLE immediately and drops cpu_enable and all write enables. Memory contents are not cleaned up.
- States: IDLE, LOAD_I, LOAD_D, RUN, RD_ISSUE, RD_WAIT, RD_OUT, DONE.
- Start transition:
  - start in IDLE or DONE latches all four counts, clears word and address counters, clears done, and goes to LOAD_I.
  - start in any other state is ignored.
- Zero counts: a zero count skips that phase in the same transition, e.g. imem_words=0 moves directly to LOAD_D. A chain of zeros may skip to DONE.
- LOAD_I:
  - s_ready=1.
  - Each s_valid&&s_ready beat drives imem_wen=1, imem_wdata=s_data, imem_addr=idx*ADDR_STEP in that same cycle (combinational from the beat).
  - The last beat (idx=imem_words-1) moves to LOAD_D.
  - Stalls with s_valid=0 hold state and index.
- LOAD_D: identical to LOAD_I using the dmem_* outputs and dmem_words. The last beat moves to RUN.
- s_ready=0 in every state other than LOAD_I and LOAD_D.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles. A registered counter counts from 0.
  - Leaving RUN, cpu_enable falls on the cycle after the last enabled cycle.
  - run_cycles=0 skips RUN.
  - No memory writes or reads occur in RUN.
- Dump sequence:
  - RD_ISSUE: dmem_ren=1 and dmem_addr=j*ADDR_STEP for one cycle, then go to RD_WAIT.
  - RD_WAIT: dmem_addr held. After RD_LAT cycles counted from the issue cycle, capture dmem_rdata into m_data and go to RD_OUT.
  - RD_OUT: m_valid=1 and m_data stable until m_ready.
  - On the handshake, if j=dump_words-1 go to DONE, else increment j and go to RD_ISSUE.
  - dump_words=0 skips the dump.
- Throughput: one word per RD_LAT+2 cycles at minimum.
- DONE: done=1 and busy=0. Held until the next start or reset.
- Invariant: imem_wen, dmem_wen and cpu_enable are never high in the same cycle.
- Addresses are byte addresses and wrap modulo 2^32. Counts larger than the memory size are not checked.

Test Plan:
- Reset mid-LOAD_I after 2 of 4 words, with arst_n low for 1 cycle -> outputs all 0, state IDLE, s_ready=0. A new start reloads from address 0.
- Full run:
  - Stimulus: imem_words=3, dmem_words=2, run_cycles=5, dump_words=2, streams always valid.
  - imem writes appear at 0x0, 0x4, 0x8; dmem writes at 0x0, 0x4.
  - cpu_enable is high for exactly 5 cycles.
  - 2 dump words are delivered, then done=1.
- Backpressure:
  - s_valid toggles 1,0,1,0 -> writes only on valid cycles, addresses contiguous.
  - m_ready held low 4 cycles -> m_valid and m_data held stable, with no extra dmem_ren.
- Zero counts: imem_words=0, dmem_words=0, run_cycles=0, dump_words=0 -> state goes IDLE to DONE on the cycle after start, with no wen, ren or enable activity.
- Start while busy: a pulse during RUN with run_cycles=10 -> ignored; enable count is still 10 and the counts are not re-latched.
- Dump data: preload dmem word 1 = 0xDEADBEEF via LOAD_D, dump_words=2 -> second m_data beat = 0xDEADBEEF with RD_LAT=1, and also with RD_LAT=2.
